// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier family.
// BOOTH_RADIX4_EN selects radix-4 recoding; otherwise radix-2.
package booth_pkg;

`ifdef BOOTH_RADIX4_EN
    localparam bit Radix4En = 1'b1;
`else
    localparam bit Radix4En = 1'b0;
`endif

    localparam int unsigned WinW = Radix4En ? 3 : 2;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    typedef enum logic [2:0] {OP_ZERO, OP_ADD1, OP_SUB1, OP_ADD2, OP_SUB2} booth_op_e;

    function automatic int unsigned iter_count(input int unsigned width, input bit radix4);
        return radix4 ? (width + 1) / 2 : width;
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Combinational Booth recoder: maps the low multiplier window to an add/sub operation.
// BOOTH_RADIX4_EN selects the 3-bit radix-4 table; otherwise the 2-bit radix-2 table.
module booth_recode
    import booth_pkg::*;
(
    input  logic [WinW-1:0] window_i,
    output booth_op_e       op_o
);

    always_comb begin
        op_o = OP_ZERO;
`ifdef BOOTH_RADIX4_EN
        unique case (window_i)
            3'b001, 3'b010: op_o = OP_ADD1;
            3'b011:         op_o = OP_ADD2;
            3'b100:         op_o = OP_SUB2;
            3'b101, 3'b110: op_o = OP_SUB1;
            default:        op_o = OP_ZERO;
        endcase
`else
        unique case (window_i)
            2'b01:   op_o = OP_ADD1;
            2'b10:   op_o = OP_SUB1;
            default: op_o = OP_ZERO;
        endcase
`endif
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative signed Booth multiplier, one recoding step per cycle, valid/ready on both sides.
// BOOTH_RADIX4_EN switches to radix-4 (half the iterations); default build is radix-2.
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned TAG_W = 43
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     in_a_i,
    input  logic [WIDTH-1:0]     in_b_i,
    input  logic [TAG_W-1:0]     in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   out_product_o,
    output logic [TAG_W-1:0]     out_tag_o,
    output logic                 busy_o
);

    localparam int unsigned Iter  = iter_count(WIDTH, Radix4En);
    localparam int unsigned AW    = Radix4En ? ((WIDTH + 1) / 2) * 2 : WIDTH;
    localparam int unsigned UW    = Radix4En ? WIDTH + 2 : WIDTH + 1;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned PW    = UW + LW;
    localparam int unsigned Shift = Radix4En ? 2 : 1;
    localparam int unsigned CntW  = $clog2(Iter + 1);

    state_e             state_q;
    logic [PW-1:0]      p_q;
    logic [UW-1:0]      b_q;
    logic [CntW-1:0]    cnt_q;
    logic               out_valid_q;
    logic [TAG_W-1:0]   out_tag_q;

    logic signed [AW-1:0] a_ext;
    logic [UW-1:0]        upper, upper_sum;
    logic [PW-1:0]        p_sum, p_step;
    booth_op_e            op;

    assign a_ext = AW'($signed(in_a_i));

    booth_recode u_recode (
        .window_i (p_q[WinW-1:0]),
        .op_o     (op)
    );

    always_comb begin
        upper     = p_q[PW-1 -: UW];
        upper_sum = upper;
        case (op)
            OP_ADD1: upper_sum = upper + b_q;
            OP_SUB1: upper_sum = upper - b_q;
`ifdef BOOTH_RADIX4_EN
            OP_ADD2: upper_sum = upper + (b_q << 1);
            OP_SUB2: upper_sum = upper - (b_q << 1);
`endif
            default: upper_sum = upper;
        endcase
        p_sum  = {upper_sum, p_q[LW-1:0]};
        // Arithmetic shift keeps the accumulator sign in the top bit.
        p_step = $signed(p_sum) >>> Shift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            p_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        p_q       <= {{UW{1'b0}}, a_ext, 1'b0};
                        b_q       <= UW'($signed(in_b_i));
                        out_tag_q <= in_tag_i;
                        cnt_q     <= CntW'(Iter - 1);
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    p_q <= p_step;
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o    = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign out_valid_o   = out_valid_q;
    assign out_product_o = p_q[2*WIDTH:1];
    assign out_tag_o     = out_tag_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed and random ops at WIDTH 8, 5 and 25.
// Expected iteration count follows BOOTH_RADIX4_EN when defined.
module tb_booth_seq_mult;

    localparam int unsigned TW = 43;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // WIDTH = 8 instance
    logic          in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]    a8, b8;
    logic [15:0]   prod8;
    logic [TW-1:0] tag8, otag8;

    // WIDTH = 5 instance
    logic          in_valid5, in_ready5, out_valid5, out_ready5, busy5;
    logic [4:0]    a5, b5;
    logic [9:0]    prod5;
    logic [TW-1:0] tag5, otag5;

    // WIDTH = 25 instance
    logic          in_valid25, in_ready25, out_valid25, out_ready25, busy25;
    logic [24:0]   a25, b25;
    logic [49:0]   prod25;
    logic [TW-1:0] tag25, otag25;

    booth_seq_mult #(.WIDTH(8), .TAG_W(TW)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .in_a_i(a8), .in_b_i(b8), .in_tag_i(tag8), .out_valid_o(out_valid8),
        .out_ready_i(out_ready8), .out_product_o(prod8), .out_tag_o(otag8), .busy_o(busy8)
    );

    booth_seq_mult #(.WIDTH(5), .TAG_W(TW)) u_dut5 (
        .clk(clk), .reset(reset), .in_valid_i(in_valid5), .in_ready_o(in_ready5),
        .in_a_i(a5), .in_b_i(b5), .in_tag_i(tag5), .out_valid_o(out_valid5),
        .out_ready_i(out_ready5), .out_product_o(prod5), .out_tag_o(otag5), .busy_o(busy5)
    );

    booth_seq_mult #(.WIDTH(25), .TAG_W(TW)) u_dut25 (
        .clk(clk), .reset(reset), .in_valid_i(in_valid25), .in_ready_o(in_ready25),
        .in_a_i(a25), .in_b_i(b25), .in_tag_i(tag25), .out_valid_o(out_valid25),
        .out_ready_i(out_ready25), .out_product_o(prod25), .out_tag_o(otag25), .busy_o(busy25)
    );

    function automatic int exp_iter(input int w);
`ifdef BOOTH_RADIX4_EN
        return (w + 1) / 2;
`else
        return w;
`endif
    endfunction

    function automatic logic [63:0] ref_mul(input longint a, input longint b, input int w);
        longint p;
        logic [63:0] mask;
        p    = a * b;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic [TW-1:0] tag, input int hold);
        int n;
        logic stable;
        logic [15:0] p_hold;
        logic [TW-1:0] t_hold;
        out_ready8 = (hold == 0);
        in_valid8 = 1'b1; a8 = a; b8 = b; tag8 = tag;
        n = 0;
        while (!in_ready8 && n < 100) begin tick(); n++; end
        tick();
        // Junk on the inputs outside the accept cycle must be ignored.
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); tag8 = TW'({$urandom, $urandom});
        n = 1;
        while (!out_valid8 && n < 100) begin tick(); n++; end
        check("op8_latency", 64'(n), 64'(exp_iter(8) + 1));
        check("op8_product", 64'(prod8), ref_mul(longint'(a), longint'(b), 8));
        check("op8_tag", 64'(otag8), 64'(tag));
        if (hold > 0) begin
            p_hold = prod8; t_hold = otag8; stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (!(out_valid8 && prod8 == p_hold && otag8 == t_hold && !in_ready8 && busy8))
                    stable = 1'b0;
            end
            check("op8_stall_stable", 64'(stable), 64'd1);
            out_ready8 = 1'b1;
        end
        tick();
        check("op8_handshake_idle", {61'd0, out_valid8, in_ready8, busy8}, 64'b010);
    endtask

    task automatic sweep5();
        int n;
        logic signed [4:0] a, b;
        logic [TW-1:0] tag;
        out_ready5 = 1'b1;
        for (int ia = -16; ia < 16; ia++) begin
            for (int ib = -16; ib < 16; ib++) begin
                a = 5'(ia); b = 5'(ib); tag = TW'({$urandom, $urandom});
                in_valid5 = 1'b1; a5 = a; b5 = b; tag5 = tag;
                n = 0;
                while (!in_ready5 && n < 100) begin tick(); n++; end
                tick();
                in_valid5 = 1'b0;
                n = 1;
                while (!out_valid5 && n < 100) begin tick(); n++; end
                check("w5_latency", 64'(n), 64'(exp_iter(5) + 1));
                check("w5_product", 64'(prod5), ref_mul(longint'(a), longint'(b), 5));
                check("w5_tag", 64'(otag5), 64'(tag));
                tick();
            end
        end
    endtask

    task automatic sweep25(input int count);
        int n;
        logic signed [24:0] a, b;
        logic [TW-1:0] tag;
        out_ready25 = 1'b1;
        for (int i = 0; i < count; i++) begin
            a = 25'($urandom); b = 25'($urandom);
            case (i)
                0: begin a = {1'b1, 24'd0}; b = {1'b1, 24'd0}; end
                1: begin a = {1'b1, 24'd0}; b = {1'b0, {24{1'b1}}}; end
                2: begin a = {1'b0, {24{1'b1}}}; b = {1'b0, {24{1'b1}}}; end
                3: begin a = '0; b = '1; end
                default: ;
            endcase
            tag = TW'({$urandom, $urandom});
            in_valid25 = 1'b1; a25 = a; b25 = b; tag25 = tag;
            n = 0;
            while (!in_ready25 && n < 100) begin tick(); n++; end
            tick();
            in_valid25 = 1'b0;
            n = 1;
            while (!out_valid25 && n < 100) begin tick(); n++; end
            check("w25_latency", 64'(n), 64'(exp_iter(25) + 1));
            check("w25_product", 64'(prod25), ref_mul(longint'(a), longint'(b), 25));
            check("w25_tag", 64'(otag25), 64'(tag));
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic saw, rdy_seen;
        reset = 1'b0;
        in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; tag8 = 0;
        in_valid5 = 0; out_ready5 = 1; a5 = 0; b5 = 0; tag5 = 0;
        in_valid25 = 0; out_ready25 = 1; a25 = 0; b25 = 0; tag25 = 0;
        #1;
        check("rst_ctrl8", {61'd0, out_valid8, in_ready8, busy8}, 64'b010);
        check("rst_product8", 64'(prod8), 64'd0);
        check("rst_tag8", 64'(otag8), 64'd0);
        check("rst_ctrl25", {61'd0, out_valid25, in_ready25, busy25}, 64'b010);
        tick(); tick();
        reset = 1'b1;
        tick();

        op8(8'sd3, 8'sd5, TW'(43'h11), 0);
        op8(-8'sd128, -8'sd128, TW'(43'h22), 0);
        op8(-8'sd128, 8'sd127, TW'(43'h33), 0);
        op8(8'sd0, -8'sd1, TW'(43'h44), 0);
        op8(-8'sd77, 8'sd55, TW'(43'h7_0000_0055), 10);

        // Back-to-back: second op held on the inputs while the first is in flight.
        out_ready8 = 1'b1;
        in_valid8 = 1'b1; a8 = 8'sd3; b8 = 8'sd4; tag8 = TW'(1);
        n = 0;
        while (!in_ready8 && n < 100) begin tick(); n++; end
        tick();
        a8 = -8'sd5; b8 = 8'sd6; tag8 = TW'(2);
        rdy_seen = 1'b0; n = 1;
        while (!out_valid8 && n < 100) begin
            if (in_ready8) rdy_seen = 1'b1;
            tick(); n++;
        end
        check("b2b_no_overlap", 64'(rdy_seen | in_ready8), 64'd0);
        check("b2b_first_product", 64'(prod8), 64'd12);
        check("b2b_first_tag", 64'(otag8), 64'd1);
        tick();
        check("b2b_idle_ready", 64'(in_ready8), 64'd1);
        tick();
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 100) begin tick(); n++; end
        check("b2b_second_latency", 64'(n), 64'(exp_iter(8) + 1));
        check("b2b_second_product", 64'(prod8), ref_mul(-64'sd5, 64'sd6, 8));
        check("b2b_second_tag", 64'(otag8), 64'd2);
        tick();

        // Reset three cycles into CALC discards the operation.
        in_valid8 = 1'b1; a8 = 8'sd100; b8 = 8'sd100; tag8 = TW'(43'h5A5);
        n = 0;
        while (!in_ready8 && n < 100) begin tick(); n++; end
        tick();
        in_valid8 = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b0;
        #1;
        check("midrst_ctrl", {61'd0, out_valid8, in_ready8, busy8}, 64'b010);
        check("midrst_product", 64'(prod8), 64'd0);
        check("midrst_tag", 64'(otag8), 64'd0);
        tick(); tick();
        reset = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid8) saw = 1'b1;
        end
        check("midrst_no_valid", 64'(saw), 64'd0);
        op8(8'sd7, -8'sd9, TW'(43'h1_2345_6789), 0);

        fork
            sweep5();
            sweep25(1500);
            begin
                for (int i = 0; i < 150; i++)
                    op8(8'($urandom), 8'($urandom), TW'({$urandom, $urandom}),
                        int'($urandom_range(0, 2)));
            end
        join

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
